// File: rtl/nrs_cinit_if.sv
// Handshake and operand bundle for the NRS c_init sequencer.
// master: requester side. It drives start, ns, l and n_id, and it receives busy, done, cinit and err.
// slave:  sequencer side. Its directions are the opposite of master.
// Port summary:
//   start  request pulse, sampled only while the sequencer is idle
//   ns     slot number (0..19)
//   l      OFDM symbol index in the slot (0..13)
//   n_id   cell ID (0..503)
//   busy   high while a computation is in flight
//   done   one-cycle completion pulse
//   cinit  result, valid while done is high and held afterwards
//   err    range-error flag
interface nrs_cinit_if #(
  parameter int unsigned CINIT_W = 31
);
  logic               start;
  logic [4:0]         ns;
  logic [3:0]         l;
  logic [8:0]         n_id;
  logic               busy;
  logic               done;
  logic [CINIT_W-1:0] cinit;
  logic               err;

  modport master (
    output start, ns, l, n_id,
    input  busy, done, cinit, err
  );

  modport slave (
    input  start, ns, l, n_id,
    output busy, done, cinit, err
  );
endinterface

// File: rtl/nrs_cinit_seq.sv
// Multi-cycle sequencer for the NB-IoT NRS Gold-sequence seed:
//   c_init = 2^10 * (7*(ns+1) + l + 1) * (2*n_id + 1) + 2*n_id + 1
// The sum uses one shared adder path. The product comes from an LSB-first shift-add multiplier
// that runs for MUL_BITS cycles. done goes high 4+MUL_BITS cycles after the edge that accepts start.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    nrs_cinit_if.slave (start/ns/l/n_id in; busy/done/cinit/err out)
// Optional feature: define NRS_CINIT_RANGE_CHK_EN to reject out-of-range operands.
//   A rejected start gives done with err one cycle later, and cinit keeps its value.
//   When the macro is not defined, err is tied low and out-of-range operands wrap.
module nrs_cinit_seq #(
  parameter int unsigned WIDTH    = 18,
  parameter int unsigned MUL_BITS = 10,
  parameter int unsigned CINIT_W  = 31
) (
  input logic        clk,
  input logic        rst_n,
  nrs_cinit_if.slave bus
);

  localparam int unsigned CntW = (MUL_BITS > 1) ? $clog2(MUL_BITS) : 1;

  typedef enum logic [2:0] {StIdle, StSa, StSb, StSc, StMul, StFin} state_e;

  state_e               state_q;
  logic [4:0]           ns_q;
  logic [3:0]           l_q;
  logic [8:0]           n_id_q;
  logic [7:0]           acc_q;
  logic [MUL_BITS-1:0]  m_q;
  logic [WIDTH-1:0]     prod_q;
  logic [CntW-1:0]      cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [CINIT_W-1:0]   cinit_q;

`ifdef NRS_CINIT_RANGE_CHK_EN
  logic err_q;
  logic range_bad;
  assign range_bad = (bus.ns > 5'd19) || (bus.l > 4'd13) || (bus.n_id > 9'd503);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ns_q    <= '0;
      l_q     <= '0;
      n_id_q  <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cinit_q <= '0;
`ifdef NRS_CINIT_RANGE_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
`ifdef NRS_CINIT_RANGE_CHK_EN
            if (range_bad) begin
              // Reject now: done and err appear next cycle and cinit is left alone.
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              ns_q    <= bus.ns;
              l_q     <= bus.l;
              n_id_q  <= bus.n_id;
              busy_q  <= 1'b1;
              err_q   <= 1'b0;
              state_q <= StSa;
            end
`else
            ns_q    <= bus.ns;
            l_q     <= bus.l;
            n_id_q  <= bus.n_id;
            busy_q  <= 1'b1;
            state_q <= StSa;
`endif
          end
        end
        StSa: begin
          // 7*(ns+1) as (ns<<3) - ns + 7
          acc_q   <= ({3'b000, ns_q} << 3) - {3'b000, ns_q} + 8'd7;
          state_q <= StSb;
        end
        StSb: begin
          acc_q   <= acc_q + {4'b0000, l_q} + 8'd1;
          state_q <= StSc;
        end
        StSc: begin
          m_q     <= MUL_BITS'({n_id_q, 1'b1});
          prod_q  <= '0;
          cnt_q   <= '0;
          state_q <= StMul;
        end
        StMul: begin
          if (m_q[cnt_q]) begin
            prod_q <= prod_q + (WIDTH'(acc_q) << cnt_q);
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(MUL_BITS - 1)) begin
            state_q <= StFin;
          end
        end
        StFin: begin
          cinit_q <= CINIT_W'({prod_q, 10'b0}) + CINIT_W'(m_q);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.cinit = cinit_q;
`ifdef NRS_CINIT_RANGE_CHK_EN
  assign bus.err   = err_q;
`else
  assign bus.err   = 1'b0;
`endif

endmodule

// File: tb/tb_nrs_cinit_seq.sv
module tb_nrs_cinit_seq;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  nrs_cinit_if #(.CINIT_W(31)) bus_if ();

  nrs_cinit_seq #(
    .WIDTH   (18),
    .MUL_BITS(10),
    .CINIT_W (31)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a one-cycle start pulse. On return, the time is 1 unit after the accepting edge (E0).
  task automatic do_start(input logic [4:0] ns, input logic [3:0] l, input logic [8:0] n_id);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.ns    = ns;
    bus_if.l     = l;
    bus_if.n_id  = n_id;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
  endtask

  // Counts edges after E0 until done is seen. lat is -1 if the cycle budget runs out.
  // busy_cnt counts the sample points (E0 onwards) where busy is high before done arrives.
  task automatic wait_done(input int k0, output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = bus_if.busy ? 1 : 0;
    for (int k = k0 + 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus_if.done) begin
        lat = k;
        break;
      end
      if (bus_if.busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus_if.start = 1'($urandom);
    bus_if.ns    = 5'($urandom);
    bus_if.l     = 4'($urandom);
    bus_if.n_id  = 9'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
    checks++; if (bus_if.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus_if.done); end
    checks++; if (bus_if.cinit !== 31'd0) begin errors++; $display("FAIL reset_cinit got=%0d exp=0", bus_if.cinit); end
    checks++; if (bus_if.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus_if.err); end
    bus_if.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bc;
    do_start(5'd0, 4'd5, 9'd0);
    wait_done(0, lat, bc);
    checks++; if (lat !== 14) begin errors++; $display("FAIL basic_latency got=%0d exp=14", lat); end
    checks++; if (bus_if.cinit !== 31'd13313) begin errors++; $display("FAIL basic_cinit got=%0d exp=13313", bus_if.cinit); end
    checks++; if (bus_if.err !== 1'b0) begin errors++; $display("FAIL basic_err got=%b exp=0", bus_if.err); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%b exp=0", bus_if.busy); end
    @(posedge clk);
    #1;
    checks++; if (bus_if.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", bus_if.done); end
    checks++; if (bus_if.cinit !== 31'd13313) begin errors++; $display("FAIL basic_cinit_hold got=%0d exp=13313", bus_if.cinit); end
  endtask

  task automatic test_max();
    int lat, bc;
    do_start(5'd19, 4'd6, 9'd503);
    wait_done(0, lat, bc);
    checks++; if (lat !== 14) begin errors++; $display("FAIL max_latency got=%0d exp=14", lat); end
    checks++; if (bc !== 14) begin errors++; $display("FAIL max_busy_cycles got=%0d exp=14", bc); end
    checks++; if (bus_if.cinit !== 31'd151582703) begin errors++; $display("FAIL max_cinit got=%0d exp=151582703", bus_if.cinit); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    do_start(5'd2, 4'd6, 9'd1);
    repeat (4) @(posedge clk);
    #1;
    bus_if.start = 1'b1;
    bus_if.ns    = 5'd7;
    bus_if.l     = 4'd1;
    bus_if.n_id  = 9'd100;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got=%b exp=1", bus_if.busy); end
    wait_done(5, lat, bc);
    checks++; if (lat !== 14) begin errors++; $display("FAIL ignore_latency got=%0d exp=14", lat); end
    checks++; if (bus_if.cinit !== 31'd86019) begin errors++; $display("FAIL ignore_cinit got=%0d exp=86019", bus_if.cinit); end
    @(posedge clk);
    #1;
    checks++; if (bus_if.done !== 1'b0) begin errors++; $display("FAIL b2b_done_low got=%b exp=0", bus_if.done); end
    checks++; if (bus_if.cinit !== 31'd86019) begin errors++; $display("FAIL b2b_cinit_hold got=%0d exp=86019", bus_if.cinit); end
    // 7*4=28, +0+1=29, m=21, prod=609, 609*1024+21
    do_start(5'd3, 4'd0, 9'd10);
    wait_done(0, lat, bc);
    checks++; if (lat !== 14) begin errors++; $display("FAIL b2b_latency got=%0d exp=14", lat); end
    checks++; if (bus_if.cinit !== 31'd623637) begin errors++; $display("FAIL b2b_cinit got=%0d exp=623637", bus_if.cinit); end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    do_start(5'd19, 4'd6, 9'd503);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus_if.busy); end
    checks++; if (bus_if.cinit !== 31'd0) begin errors++; $display("FAIL midrst_cinit got=%0d exp=0", bus_if.cinit); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus_if.done !== 1'b0) begin errors++; $display("FAIL midrst_done cyc=%0d got=%b exp=0", i, bus_if.done); end
    end
    rst_n = 1'b1;
    // With no restart, the sequence must not complete after release.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      checks++; if (bus_if.done !== 1'b0) begin errors++; $display("FAIL midrst_no_done cyc=%0d got=%b exp=0", i, bus_if.done); end
    end
    do_start(5'd0, 4'd5, 9'd0);
    wait_done(0, lat, bc);
    checks++; if (lat !== 14) begin errors++; $display("FAIL midrst_latency got=%0d exp=14", lat); end
    checks++; if (bus_if.cinit !== 31'd13313) begin errors++; $display("FAIL midrst_cinit_after got=%0d exp=13313", bus_if.cinit); end
  endtask

  task automatic test_range();
    int lat, bc;
`ifdef NRS_CINIT_RANGE_CHK_EN
    do_start(5'd20, 4'd0, 9'd0);
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL range_busy got=%b exp=0", bus_if.busy); end
    checks++; if (bus_if.done !== 1'b1) begin errors++; $display("FAIL range_done got=%b exp=1", bus_if.done); end
    checks++; if (bus_if.err !== 1'b1) begin errors++; $display("FAIL range_err got=%b exp=1", bus_if.err); end
    checks++; if (bus_if.cinit !== 31'd13313) begin errors++; $display("FAIL range_cinit got=%0d exp=13313", bus_if.cinit); end
    do_start(5'd0, 4'd0, 9'd504);
    checks++; if (bus_if.done !== 1'b1 || bus_if.err !== 1'b1) begin errors++; $display("FAIL range_nid got=%b%b exp=11", bus_if.done, bus_if.err); end
    do_start(5'd0, 4'd5, 9'd0);
    checks++; if (bus_if.err !== 1'b0) begin errors++; $display("FAIL range_err_clear got=%b exp=0", bus_if.err); end
    wait_done(0, lat, bc);
    checks++; if (lat !== 14) begin errors++; $display("FAIL range_legal_latency got=%0d exp=14", lat); end
`else
    // Unchecked path: 7*21=147, +1=148, m=1, result 148*1024+1
    do_start(5'd20, 4'd0, 9'd0);
    wait_done(0, lat, bc);
    checks++; if (lat !== 14) begin errors++; $display("FAIL range_latency got=%0d exp=14", lat); end
    checks++; if (bus_if.err !== 1'b0) begin errors++; $display("FAIL range_err got=%b exp=0", bus_if.err); end
    checks++; if (bus_if.cinit !== 31'd151553) begin errors++; $display("FAIL range_cinit got=%0d exp=151553", bus_if.cinit); end
`endif
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    bus_if.start = 1'b0;
    bus_if.ns    = '0;
    bus_if.l     = '0;
    bus_if.n_id  = '0;
    test_reset();
    test_basic();
    test_max();
    test_back_to_back();
    test_reset_mid();
    test_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
